ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ALU op and the two register operands latched by ID/EX. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively over 32 cycles, and asserts BUSYWAIT so ID/EX and the upstream stages hold until the result is ready.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- IN_ALU_OP  input  5  op from ID/EX: MUL=5'b01000, MULH=01001, MULHSU=01010, MULHU=01011, DIV=01100, DIVU=01101, REM=01110, REMU=01111; any other value = not a muldiv op
- IN_DATA1  input  32  rs1 operand from ID/EX
- IN_DATA2  input  32  rs2 operand from ID/EX
- IN_STALL  input  1  pipeline held by another source (e.g. data-memory busywait)
- OUT_RESULT  output  32  result, valid only while OUT_VALID=1
- OUT_VALID  output  1  result ready this cycle
- BUSYWAIT  output  1  stall request to ID/EX and earlier stages

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - BUSYWAIT = combinational (IN_ALU_OP is a muldiv op).
  - On the next edge with a muldiv op present, latch the op and operand magnitudes, record the result sign, and load count=31.
  - Then go to BUSY, or straight to DONE for the special cases below.
- BUSY:
  - BUSYWAIT=1.
  - One iteration per cycle. Multiply uses radix-2 shift-add into a 64-bit accumulator. Divide uses restoring shift-subtract producing a 32-bit quotient and remainder.
  - On count=0, apply sign correction and go to DONE; otherwise decrement count.
- DONE:
  - OUT_VALID=1, BUSYWAIT=0, OUT_RESULT held.
  - Next edge goes to IDLE if IN_STALL=0; otherwise stay in DONE with the result held.
  - A muldiv op reaching IDLE after DONE is a new instruction and starts a new operation.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Result selection:
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Negate the 64-bit product when the operand signs differ.
  - Quotient sign = sign1 XOR sign2. Remainder sign = sign of dividend.
- Special cases, resolved in the IDLE->DONE transition with no BUSY cycles:
  - Divide by zero: quotient = 32'hFFFFFFFF; remainder = IN_DATA1.
  - Signed overflow (DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF): quotient = 32'h80000000; remainder = 0.
- Non-muldiv ops: unit stays in IDLE with OUT_VALID=0 and BUSYWAIT=0.

## Timing
- Reset (RESET=0, asynchronous, any state including mid-BUSY):
  - state=IDLE, count=0.
  - OUT_RESULT=0, OUT_VALID=0, BUSYWAIT=0 immediately while RESET=0.
  - The in-flight operation is discarded.
- Normal op, cycles counted from ID/EX presenting the op (cycle 0):
  - BUSYWAIT=1 for cycles 0..32 (33 cycles).
  - Cycle 33 is DONE: OUT_VALID=1, BUSYWAIT=0.
  - ID/EX advances at the end of cycle 33.
- Special-case op: BUSYWAIT=1 in cycle 0 only; DONE in cycle 1.
- Operands are sampled once at the IDLE edge. Changes on IN_DATA1/IN_DATA2 during BUSY are ignored.
- IN_STALL has no effect in IDLE or BUSY.
- Back-to-back muldiv ops: the second op's cycle 0 starts the cycle after DONE. There are no dead cycles beyond DONE.

## Test plan
- MUL, 7 × 32'hFFFFFFFD (-3):
  - BUSYWAIT high exactly 33 cycles.
  - Then one cycle with OUT_VALID=1 and OUT_RESULT=32'hFFFFFFEB.
- MULH 32'h80000000 × 32'h80000000 -> 32'h40000000.
- MULHU 32'hFFFFFFFF × 32'hFFFFFFFF -> 32'hFFFFFFFE.
- MULHSU 32'hFFFFFFFF × 32'h00000002 -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0: BUSYWAIT high 1 cycle, then OUT_RESULT=32'hFFFFFFFF. REMU 5/0 -> 5.
- DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM of the same operands -> 0. Both take 1 busy cycle.
- Reset mid-operation: drop RESET at BUSY cycle 10 of a MUL.
  - Outputs go to 0 immediately.
  - After release with a non-muldiv op present: BUSYWAIT=0, OUT_VALID=0.
- Stall in DONE: hold IN_STALL=1 for 3 cycles on reaching DONE of DIVU 100/7.
  - OUT_VALID=1 and OUT_RESULT=14 for all 4 cycles.
  - No restart occurs, then return to IDLE.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: 32 shift-add or restoring
// shift-subtract steps, holding the upstream pipeline via BUSYWAIT until DONE.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [4:0]      IN_ALU_OP,
   input  logic [XLEN-1:0] IN_DATA1,
   input  logic [XLEN-1:0] IN_DATA2,
   input  logic            IN_STALL,
   output logic [XLEN-1:0] OUT_RESULT,
   output logic            OUT_VALID,
   output logic            BUSYWAIT,
   output logic [1:0]      DBG_STATE
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state;
   logic [4:0]      count;
   logic [2:0]      op_q;
   logic            neg_q;
   logic            rem_neg_q;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] result_q;

   logic            is_md;
   logic            in_div;
   logic [1:0]      in_sel;
   logic            in_s1;
   logic            in_s2;
   logic            neg1;
   logic            neg2;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] special_res;

   // Operand decode for the op sitting in ID/EX; only sampled in IDLE.
   always_comb begin
      is_md    = (IN_ALU_OP[4:3] == 2'b01);
      in_div   = IN_ALU_OP[2];
      in_sel   = IN_ALU_OP[1:0];
      in_s1    = in_div ? ~in_sel[0] : (in_sel != 2'b11);
      in_s2    = in_div ? ~in_sel[0] : ~in_sel[1];
      neg1     = in_s1 & IN_DATA1[XLEN-1];
      neg2     = in_s2 & IN_DATA2[XLEN-1];
      mag1     = neg1 ? -IN_DATA1 : IN_DATA1;
      mag2     = neg2 ? -IN_DATA2 : IN_DATA2;
      div_zero = in_div && (IN_DATA2 == '0);
      div_ovf  = in_div && ~in_sel[0] && (IN_DATA1 == MIN_INT) && (IN_DATA2 == '1);
      if (div_zero)
         special_res = in_sel[1] ? IN_DATA1 : '1;
      else
         special_res = in_sel[1] ? '0 : MIN_INT;
   end

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [XLEN-1:0]   nxt_hi;
   logic [XLEN-1:0]   nxt_lo;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   final_res;

   // One iteration: acc_hi/acc_lo hold product-high/multiplier for multiply,
   // partial remainder/dividend-becoming-quotient for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            nxt_hi = div_diff[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         nxt_hi = mul_sum[XLEN:1];
         nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
      prod     = {nxt_hi, nxt_lo};
      prod_fix = neg_q ? -prod : prod;
      if (!op_q[2])
         final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else if (op_q[1])
         final_res = rem_neg_q ? -nxt_hi : nxt_hi;
      else
         final_res = neg_q ? -nxt_lo : nxt_lo;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= S_IDLE;
         count     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opb       <= '0;
         result_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_md) begin
                  op_q      <= IN_ALU_OP[2:0];
                  neg_q     <= neg1 ^ neg2;
                  rem_neg_q <= neg1;
                  acc_hi    <= '0;
                  acc_lo    <= mag1;
                  opb       <= mag2;
                  count     <= 5'd31;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     state    <= S_DONE;
                  end else begin
                     state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               if (count == 5'd0) begin
                  result_q <= final_res;
                  state    <= S_DONE;
               end else begin
                  count <= count - 5'd1;
               end
            end
            S_DONE: begin
               if (!IN_STALL)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // BUSYWAIT is combinational on the op in IDLE, so it is gated by reset too.
   assign BUSYWAIT   = RESET && (((state == S_IDLE) && is_md) || (state == S_BUSY));
   assign OUT_VALID  = (state == S_DONE);
   assign OUT_RESULT = result_q;
   assign DBG_STATE  = state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M corner cases plus
// randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam logic [4:0] OP_MUL    = 5'b01000;
   localparam logic [4:0] OP_MULH   = 5'b01001;
   localparam logic [4:0] OP_MULHSU = 5'b01010;
   localparam logic [4:0] OP_MULHU  = 5'b01011;
   localparam logic [4:0] OP_DIV    = 5'b01100;
   localparam logic [4:0] OP_DIVU   = 5'b01101;
   localparam logic [4:0] OP_REM    = 5'b01110;
   localparam logic [4:0] OP_REMU   = 5'b01111;
   localparam logic [31:0] MIN_INT  = 32'h80000000;

   logic        CLK;
   logic        RESET;
   logic [4:0]  IN_ALU_OP;
   logic [31:0] IN_DATA1;
   logic [31:0] IN_DATA2;
   logic        IN_STALL;
   logic [31:0] OUT_RESULT;
   logic        OUT_VALID;
   logic        BUSYWAIT;
   logic [1:0]  DBG_STATE;

   int pass_cnt  = 0;
   int check_cnt = 0;
   logic [31:0] exp_q[$];

   ex_muldiv_unit #(.XLEN(32)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .IN_ALU_OP(IN_ALU_OP),
      .IN_DATA1(IN_DATA1),
      .IN_DATA2(IN_DATA2),
      .IN_STALL(IN_STALL),
      .OUT_RESULT(OUT_RESULT),
      .OUT_VALID(OUT_VALID),
      .BUSYWAIT(BUSYWAIT),
      .DBG_STATE(DBG_STATE)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference model: plain 64-bit arithmetic on the architectural definition
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      logic [63:0] pv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MUL:    begin p = sa * sb; pv = p; return pv[31:0]; end
         OP_MULH:   begin p = sa * sb; pv = p; return pv[63:32]; end
         OP_MULHSU: begin p = sa * longint'({32'b0, b}); pv = p; return pv[63:32]; end
         OP_MULHU:  begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == MIN_INT && b == 32'hFFFFFFFF) return MIN_INT;
            p = sa / sb; pv = p; return pv[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb; pv = p; return pv[31:0];
         end
         OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
         OP_REMU: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int exp_busy(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == MIN_INT && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   // driver: caller is positioned just after a rising edge; returns likewise
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall_n, input string name);
      int busy;
      int want_busy;
      bit got;
      logic [31:0] exp;
      exp_q.push_back(model(op, a, b));
      want_busy = exp_busy(op, a, b);
      IN_ALU_OP = op;
      IN_DATA1  = a;
      IN_DATA2  = b;
      IN_STALL  = (stall_n > 0);
      busy = 0;
      got  = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge CLK);
         if (OUT_VALID) got = 1'b1;
         else begin
            if (BUSYWAIT) busy++;
            @(posedge CLK);
            #1;
            IN_DATA1 = $urandom;
            IN_DATA2 = $urandom;
         end
      end
      exp = exp_q.pop_front();
      check_cnt++;
      if (!got) $display("FAIL %s timeout: OUT_VALID never rose, required within 100 cycles", name);
      else pass_cnt++;
      check_cnt++;
      if (busy !== want_busy) $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy, want_busy);
      else pass_cnt++;
      check_cnt++;
      if (OUT_RESULT !== exp || BUSYWAIT !== 1'b0)
         $display("FAIL %s result: got %h busywait=%b, required %h busywait=0", name, OUT_RESULT, BUSYWAIT, exp);
      else pass_cnt++;
      for (int k = 0; k < stall_n; k++) begin
         @(posedge CLK);
         #1;
         if (k == stall_n - 1) IN_STALL = 1'b0;
         @(negedge CLK);
         check_cnt++;
         if (OUT_VALID !== 1'b1 || OUT_RESULT !== exp)
            $display("FAIL %s stall_hold%0d: valid=%b result=%h, required valid=1 result=%h",
                     name, k, OUT_VALID, OUT_RESULT, exp);
         else pass_cnt++;
      end
      @(posedge CLK);
      #1;
      IN_ALU_OP = 5'b00000;
      IN_STALL  = 1'b0;
   endtask

   task automatic check_idle(input string name);
      @(negedge CLK);
      check_cnt++;
      if (OUT_VALID !== 1'b0 || BUSYWAIT !== 1'b0)
         $display("FAIL %s idle: valid=%b busywait=%b, required 0 0", name, OUT_VALID, BUSYWAIT);
      else pass_cnt++;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      IN_ALU_OP = OP_MUL;
      IN_DATA1 = 32'd3;
      IN_DATA2 = 32'd4;
      IN_STALL = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_cnt++;
      if (OUT_RESULT !== 32'h0 || OUT_VALID !== 1'b0 || BUSYWAIT !== 1'b0)
         $display("FAIL reset_outputs: result=%h valid=%b busywait=%b, required 0 0 0", OUT_RESULT, OUT_VALID, BUSYWAIT);
      else pass_cnt++;
      IN_ALU_OP = 5'b00000;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check_idle("after_reset");
   endtask

   task automatic test_directed();
      run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 0, "mul_7_m3");              check_idle("mul_7_m3");
      run_op(OP_MULH, MIN_INT, MIN_INT, 0, "mulh_min_min");            check_idle("mulh");
      run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu_ones");   check_idle("mulhu");
      run_op(OP_MULHSU, 32'hFFFFFFFF, 32'h2, 0, "mulhsu_m1_2");        check_idle("mulhsu");
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");              check_idle("div");
      run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 0, "rem_m7_2");              check_idle("rem");
      run_op(OP_DIVU, 32'd100, 32'd7, 0, "divu_100_7");                check_idle("divu");
      run_op(OP_REMU, 32'd100, 32'd7, 0, "remu_100_7");                check_idle("remu");
   endtask

   task automatic test_special();
      run_op(OP_DIVU, 32'd5, 32'd0, 0, "divu_by_zero");                check_idle("divu0");
      run_op(OP_REMU, 32'd5, 32'd0, 0, "remu_by_zero");                check_idle("remu0");
      run_op(OP_DIV, MIN_INT, 32'hFFFFFFFF, 0, "div_overflow");        check_idle("divovf");
      run_op(OP_REM, MIN_INT, 32'hFFFFFFFF, 0, "rem_overflow");        check_idle("removf");
      run_op(OP_REM, 32'hFFFFFFF0, 32'd0, 0, "rem_signed_by_zero");    check_idle("rem0");
   endtask

   task automatic test_stall_done();
      run_op(OP_DIVU, 32'd100, 32'd7, 3, "divu_stall");
      check_idle("after_stall");
   endtask

   task automatic test_back_to_back();
      run_op(OP_MUL, 32'd12345, 32'd678, 0, "b2b_first");
      run_op(OP_DIV, 32'hFFFF0000, 32'd9, 0, "b2b_second");
      run_op(OP_REMU, 32'd77, 32'd0, 0, "b2b_third");
      check_idle("b2b");
   endtask

   task automatic test_non_muldiv();
      logic [4:0] op;
      for (int i = 0; i < 8; i++) begin
         op = 5'($urandom_range(0, 31));
         while (op[4:3] == 2'b01) op = 5'($urandom_range(0, 31));
         IN_ALU_OP = op;
         IN_DATA1 = $urandom;
         IN_DATA2 = $urandom;
         check_idle("non_muldiv");
      end
      IN_ALU_OP = 5'b00000;
   endtask

   task automatic test_reset_mid_op();
      IN_ALU_OP = OP_MUL;
      IN_DATA1 = 32'd55;
      IN_DATA2 = 32'd66;
      @(posedge CLK);
      repeat (9) @(posedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      check_cnt++;
      if (OUT_RESULT !== 32'h0 || OUT_VALID !== 1'b0 || BUSYWAIT !== 1'b0)
         $display("FAIL reset_mid_op: result=%h valid=%b busywait=%b, required 0 0 0", OUT_RESULT, OUT_VALID, BUSYWAIT);
      else pass_cnt++;
      IN_ALU_OP = 5'b00011;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check_idle("post_reset_1");
      check_idle("post_reset_2");
      run_op(OP_MULHU, 32'h12345678, 32'h9ABCDEF0, 0, "recover_mulhu");
      check_idle("recover");
   endtask

   task automatic test_random();
      logic [4:0] op;
      logic [31:0] a, b;
      int sel;
      for (int i = 0; i < 24; i++) begin
         op  = {2'b01, 3'($urandom_range(0, 7))};
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'h0;
         else if (sel == 1) begin a = MIN_INT; b = 32'hFFFFFFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         else if (sel == 3) a = 32'($urandom_range(0, 255));
         run_op(op, a, b, 0, "random");
         if ($urandom_range(0, 1) == 1) check_idle("random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_stall_done();
      test_back_to_back();
      test_non_muldiv();
      test_reset_mid_op();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
